// File: rtl/vga_timing_gen.sv
// VGA timing generator for the Pong renderer and game logic.
// Produces the pixel counters, sync pulses and active-video flag, the
// line/frame strobes and a slow game tick. Everything runs on clk.
module vga_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_POL    = 1'b0,
    parameter int PIX_DIV     = 1,
    parameter int TICK_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       display_on,
    output logic       hsync,
    output logic       vsync,
    output logic       pix_stb,
    output logic       line_start,
    output logic       frame_start,
    output logic       game_tick,
    output logic [5:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [1:0] DIV_LAST = 2'(PIX_DIV - 1);
    localparam logic [5:0] TICK_LAST = 6'(TICK_FRAMES - 1);

    // Strobe FSM: WRAP lasts exactly the one clk in which a wrap strobe is shown.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WRAP = 1'b1
    } strb_state_e;

    strb_state_e state_q, state_d;

    logic [1:0] div_q, div_d;
    logic [9:0] pix_x_q, pix_x_d;
    logic [9:0] pix_y_q, pix_y_d;
    logic [5:0] frame_count_q, frame_count_d;
    logic [5:0] tick_cnt_q, tick_cnt_d;
    logic       display_on_q, display_on_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       pix_stb_q, pix_stb_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       game_tick_q, game_tick_d;

    logic stb;
    logic x_wrap;
    logic y_wrap;
    logic wrap_ok;

    // Next-state logic: divider, counters, strobes and the decode of the new position.
    always_comb begin
        div_d         = div_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        frame_count_d = frame_count_q;
        tick_cnt_d    = tick_cnt_q;
        game_tick_d   = 1'b0;

        stb    = en && (div_q == DIV_LAST);
        x_wrap = (pix_x_q == H_LAST);
        y_wrap = (pix_y_q == V_LAST);

        if (en) begin
            div_d = (div_q == DIV_LAST) ? 2'd0 : div_q + 2'd1;
        end

        if (stb) begin
            if (x_wrap) begin
                pix_x_d = 10'd0;
                pix_y_d = y_wrap ? 10'd0 : pix_y_q + 10'd1;
            end else begin
                pix_x_d = pix_x_q + 10'd1;
            end
        end

        // A wrap strobe is only raised from IDLE, so it can never stretch.
        wrap_ok       = stb && x_wrap && (state_q == S_IDLE);
        state_d       = wrap_ok ? S_WRAP : S_IDLE;
        pix_stb_d     = stb;
        line_start_d  = wrap_ok;
        frame_start_d = wrap_ok && y_wrap;

        if (frame_start_d) begin
            frame_count_d = (frame_count_q == 6'd59) ? 6'd0 : frame_count_q + 6'd1;
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_d  = 6'd0;
                game_tick_d = 1'b1;
            end else begin
                tick_cnt_d  = tick_cnt_q + 6'd1;
            end
        end

        // Decode from the next position so the flags line up with pix_x/pix_y.
        display_on_d = (pix_x_d < H_VIS) && (pix_y_d < V_VIS);
        hsync_d      = ((pix_x_d >= HS_START) && (pix_x_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d      = ((pix_y_d >= VS_START) && (pix_y_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
    end

    // Strobe FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= 2'd0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            frame_count_q <= 6'd0;
            tick_cnt_q    <= 6'd0;
            display_on_q  <= 1'b1;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            pix_stb_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            game_tick_q   <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_count_q <= frame_count_d;
            tick_cnt_q    <= tick_cnt_d;
            display_on_q  <= display_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            pix_stb_q     <= pix_stb_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            game_tick_q   <= game_tick_d;
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign display_on  = display_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign pix_stb     = pix_stb_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign game_tick   = game_tick_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full 640x480 timing, a PIX_DIV=2 copy,
// and a tiny 16x10 geometry copy used for frame-level behaviour.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;

    always #5 clk = ~clk;

    // Full-size instance, PIX_DIV=1.
    logic [9:0] f_x, f_y;
    logic       f_don, f_hs, f_vs, f_stb, f_ls, f_fs, f_gt;
    logic [5:0] f_fc;
    // Full-size instance, PIX_DIV=2.
    logic [9:0] d_x, d_y;
    logic       d_don, d_hs, d_vs, d_stb, d_ls, d_fs, d_gt;
    logic [5:0] d_fc;
    // Small instance: H_TOTAL=16 (hsync x 10..12), V_TOTAL=10 (vsync y 7..8), 160 clks/frame.
    logic [9:0] s_x, s_y;
    logic       s_don, s_hs, s_vs, s_stb, s_ls, s_fs, s_gt;
    logic [5:0] s_fc;

    vga_timing_gen u_full (
        .clk(clk), .rst(rst), .en(en), .pix_x(f_x), .pix_y(f_y), .display_on(f_don),
        .hsync(f_hs), .vsync(f_vs), .pix_stb(f_stb), .line_start(f_ls),
        .frame_start(f_fs), .game_tick(f_gt), .frame_count(f_fc)
    );

    vga_timing_gen #(.PIX_DIV(2)) u_div2 (
        .clk(clk), .rst(rst), .en(en), .pix_x(d_x), .pix_y(d_y), .display_on(d_don),
        .hsync(d_hs), .vsync(d_vs), .pix_stb(d_stb), .line_start(d_ls),
        .frame_start(d_fs), .game_tick(d_gt), .frame_count(d_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .TICK_FRAMES(4)
    ) u_small (
        .clk(clk), .rst(rst), .en(en), .pix_x(s_x), .pix_y(s_y), .display_on(s_don),
        .hsync(s_hs), .vsync(s_vs), .pix_stb(s_stb), .line_start(s_ls),
        .frame_start(s_fs), .game_tick(s_gt), .frame_count(s_fc)
    );

    // Event counters, one observation per clk on the falling edge.
    int f_hs_low, f_don_cnt, f_vs_low, f_ls_cnt;
    int d_ls_cnt;
    int s_fs_cnt, s_gt_cnt, s_vs_low, s_don_cnt, s_hs_low, s_ls_cnt;

    always @(negedge clk) begin
        if (rst) begin
            f_hs_low = 0; f_don_cnt = 0; f_vs_low = 0; f_ls_cnt = 0; d_ls_cnt = 0;
            s_fs_cnt = 0; s_gt_cnt = 0; s_vs_low = 0; s_don_cnt = 0; s_hs_low = 0; s_ls_cnt = 0;
        end else begin
            if (!f_hs) f_hs_low++;
            if (f_don) f_don_cnt++;
            if (!f_vs) f_vs_low++;
            if (f_ls)  f_ls_cnt++;
            if (d_ls)  d_ls_cnt++;
            if (s_fs)  s_fs_cnt++;
            if (s_gt)  s_gt_cnt++;
            if (!s_vs) s_vs_low++;
            if (s_don) s_don_cnt++;
            if (!s_hs) s_hs_low++;
            if (s_ls)  s_ls_cnt++;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cur     = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance to k active clks after the last reset release.
    task automatic goto_state(input int k);
        step(k - cur);
        cur = k;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        step(4);
        // Reset state.
        check("rst_pix_x", f_x, 0);
        check("rst_pix_y", f_y, 0);
        check("rst_display_on", f_don, 1);
        check("rst_hsync", f_hs, 1);
        check("rst_vsync", f_vs, 1);
        check("rst_pix_stb", f_stb, 0);
        check("rst_line_start", f_ls, 0);
        check("rst_frame_start", f_fs, 0);
        check("rst_game_tick", f_gt, 0);
        check("rst_frame_count", f_fc, 0);
        check("rst_div2_stb", d_stb, 0);
        check("rst_div2_don", d_don, 1);
        check("rst_div2_hs", d_hs, 1);
        check("rst_div2_vs", d_vs, 1);
        check("rst_div2_fs", d_fs, 0);
        check("rst_div2_gt", d_gt, 0);
        check("rst_div2_fc", d_fc, 0);
        rst = 1'b0;
        cur = 0;

        // Small geometry position decode.
        goto_state(87);
        check("s87_display_on", s_don, 1);
        check("s87_hsync", s_hs, 1);
        goto_state(88);
        check("s88_display_on", s_don, 0);
        goto_state(122);
        check("s122_pix_x", s_x, 10);
        check("s122_hsync", s_hs, 0);
        check("s122_vsync", s_vs, 0);
        goto_state(159);
        check("s159_frame_start", s_fs, 0);
        check("s159_pix_x", s_x, 15);
        check("s159_pix_y", s_y, 9);
        goto_state(160);
        check("s160_frame_start", s_fs, 1);
        check("s160_pix_x", s_x, 0);
        check("s160_pix_y", s_y, 0);
        check("s160_frame_count", s_fc, 1);

        // Full geometry horizontal boundaries.
        goto_state(639);
        check("f639_display_on", f_don, 1);
        goto_state(640);
        check("f640_display_on", f_don, 0);
        goto_state(655);
        check("f655_hsync", f_hs, 1);
        goto_state(656);
        check("f656_hsync", f_hs, 0);
        goto_state(751);
        check("f751_hsync", f_hs, 0);
        goto_state(752);
        check("f752_hsync", f_hs, 1);
        goto_state(800);
        check("f800_pix_x", f_x, 0);
        check("f800_pix_y", f_y, 1);
        check("f800_line_start", f_ls, 1);
        check("f800_pix_stb", f_stb, 1);
        check("f800_hsync_low_clks", f_hs_low, 96);
        check("f800_prior_line_starts", f_ls_cnt, 0);
        check("d800_pix_x", d_x, 400);
        check("d800_pix_stb", d_stb, 1);
        goto_state(801);
        check("f801_line_start", f_ls, 0);
        check("d801_pix_stb", d_stb, 0);
        check("d801_pix_x", d_x, 400);

        // PIX_DIV=2 line period.
        goto_state(1599);
        check("d1599_line_start", d_ls, 0);
        goto_state(1600);
        check("d1600_line_start", d_ls, 1);
        check("d1600_pix_x", d_x, 0);
        check("d1600_pix_y", d_y, 1);
        goto_state(1601);
        check("d1601_line_start", d_ls, 0);
        goto_state(3200);
        check("d3200_line_start", d_ls, 1);
        check("d3200_pix_y", d_y, 2);

        // Small geometry: frame_count roll and game tick.
        goto_state(9440);
        check("s9440_frame_start", s_fs, 1);
        check("s9440_frame_count", s_fc, 59);
        goto_state(9600);
        check("s9600_frame_start", s_fs, 1);
        check("s9600_frame_count", s_fc, 0);
        check("s9600_game_tick", s_gt, 1);
        goto_state(10240);
        check("s10240_frame_start", s_fs, 1);
        check("s10240_game_tick", s_gt, 1);
        check("s10240_frame_count", s_fc, 4);
        check("s_frame_starts_before", s_fs_cnt, 63);
        check("s_game_ticks_before", s_gt_cnt, 15);
        check("s_vsync_low_clks", s_vs_low, 2048);
        check("s_display_on_clks", s_don_cnt, 3072);
        check("s_hsync_low_clks", s_hs_low, 1920);
        check("s_line_starts", s_ls_cnt, 639);
        check("f_hsync_low_clks", f_hs_low, 1152);
        check("f_display_on_clks", f_don_cnt, 8320);
        check("f_vsync_low_clks", f_vs_low, 0);
        check("f_line_starts", f_ls_cnt, 12);
        check("d_line_starts", d_ls_cnt, 6);

        // Mid-operation reset.
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        cur = 0;
        goto_state(1205);
        check("s1205_pix_x", s_x, 5);
        check("s1205_pix_y", s_y, 5);
        check("s1205_frame_count", s_fc, 7);
        rst = 1'b1;
        step(1);
        check("midrst_pix_x", s_x, 0);
        check("midrst_pix_y", s_y, 0);
        check("midrst_frame_count", s_fc, 0);
        check("midrst_frame_start", s_fs, 0);
        check("midrst_line_start", s_ls, 0);
        rst = 1'b0;
        cur = 0;
        goto_state(159);
        check("post_rst_s159_frame_start", s_fs, 0);
        goto_state(160);
        check("post_rst_s160_frame_start", s_fs, 1);
        check("post_rst_s160_frame_count", s_fc, 1);

        // Enable freeze at (100,5).
        goto_state(4100);
        check("pre_freeze_pix_x", f_x, 100);
        check("pre_freeze_pix_y", f_y, 5);
        en = 1'b0;
        step(1);
        check("freeze1_pix_x", f_x, 100);
        check("freeze1_pix_stb", f_stb, 0);
        step(49);
        check("freeze50_pix_x", f_x, 100);
        check("freeze50_pix_y", f_y, 5);
        check("freeze50_pix_stb", f_stb, 0);
        check("freeze50_line_start", f_ls, 0);
        check("freeze50_div2_stb", d_stb, 0);
        en = 1'b1;
        step(1);
        check("resume_pix_x", f_x, 101);
        check("resume_pix_stb", f_stb, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
